// File: rtl/stack_seq_pkg.sv
// -----------------------------------------------------------------------------
// stack_seq_pkg
// Shared definitions for the stack access sequencer:
//   - state_t : sequencer FSM states
//   - SP_*    : sp_op command encodings understood by the I/O register file
//   - op_t    : kind of stack operation selected from the start strobes
//   - pick_op : start arbitration, priority call > ret > push > pop
// -----------------------------------------------------------------------------
package stack_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_L,
        ST_PUSH_H,
        ST_POP_A,
        ST_POP_H,
        ST_POP_L,
        ST_POP_D
    } state_t;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CALL,
        OP_RET,
        OP_PUSH,
        OP_POP
    } op_t;

    // Only the highest-priority start wins; the others are dropped.
    function automatic op_t pick_op(input logic call, input logic ret,
                                    input logic push, input logic pop);
        if (call)      return OP_CALL;
        else if (ret)  return OP_RET;
        else if (push) return OP_PUSH;
        else if (pop)  return OP_POP;
        else           return OP_NONE;
    endfunction

endpackage

// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
// Stack access sequencer: drives the data-RAM port and the sp_op commands for
// PUSH, POP, CALL (16-bit return-address push) and RET/RETI (16-bit pop).
// A local copy of the stack pointer (sp_q) is used for all addressing so the
// sequence does not depend on register-file update latency.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_call/ret/push/pop  operation starts (priority call>ret>push>pop)
//   pc_in[15:0]         return address for CALL (sampled on start)
//   push_data[7:0]      byte for PUSH (sampled on start)
//   spl, sph            current stack pointer (sampled on start from IDLE)
//   ram_rdata[7:0]      RAM read data, one cycle after ram_re
//   ram_adr[ADR_W-1:0]  RAM address
//   ram_we, ram_re      RAM write / read strobes
//   ram_wdata[7:0]      RAM write data (holds outside write states)
//   sp_op[1:0]          00 hold, 01 increment, 10 decrement
//   busy                sequence in progress
//   done                pulse in the final cycle of each operation
//   pc_out, pc_load     popped return address and its strobe
//   pop_data            popped byte, valid from POP done until next POP
// -----------------------------------------------------------------------------
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int ADR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_call,
    input  logic             start_ret,
    input  logic             start_push,
    input  logic             start_pop,
    input  logic [15:0]      pc_in,
    input  logic [7:0]       push_data,
    input  logic [7:0]       spl,
    input  logic [7:0]       sph,
    input  logic [7:0]       ram_rdata,
    output logic [ADR_W-1:0] ram_adr,
    output logic             ram_we,
    output logic             ram_re,
    output logic [7:0]       ram_wdata,
    output logic [1:0]       sp_op,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pc_out,
    output logic             pc_load,
    output logic [7:0]       pop_data
);

    state_t      state_q, state_d;
    logic [15:0] sp_q;        // stack pointer at operation start
    logic        call_q;      // PUSH_L continues to PUSH_H
    logic        ret_q;       // POP_A continues to POP_H
    logic [7:0]  wdata_q;
    logic [7:0]  pch_hold_q;  // CALL high byte waiting for PUSH_H
    logic [7:0]  pch_q;       // RET high byte popped in POP_H
    logic [15:0] pc_q;
    logic [7:0]  pop_q;

    logic [15:0] adr16;
    logic [15:0] sp_fin;      // SP the register file will hold after this edge
    logic [15:0] sp_base;
    logic        accept;
    op_t         op;

    always_comb begin
        state_d = state_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        sp_op   = SP_HOLD;
        busy    = (state_q != ST_IDLE);
        done    = 1'b0;
        pc_load = 1'b0;
        adr16   = 16'h0000;
        sp_fin  = sp_q;

        case (state_q)
            ST_IDLE: ;
            ST_PUSH_L: begin
                ram_we = 1'b1;
                adr16  = sp_q;
                sp_op  = SP_DEC;
                if (call_q) begin
                    state_d = ST_PUSH_H;
                end else begin
                    done    = 1'b1;
                    sp_fin  = sp_q - 16'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH_H: begin
                ram_we  = 1'b1;
                adr16   = sp_q - 16'd1;
                sp_op   = SP_DEC;
                done    = 1'b1;
                sp_fin  = sp_q - 16'd2;
                state_d = ST_IDLE;
            end
            ST_POP_A: begin
                ram_re  = 1'b1;
                adr16   = sp_q + 16'd1;
                sp_op   = SP_INC;
                state_d = ret_q ? ST_POP_H : ST_POP_D;
            end
            ST_POP_H: begin
                ram_re  = 1'b1;
                adr16   = sp_q + 16'd2;
                sp_op   = SP_INC;
                state_d = ST_POP_L;
            end
            ST_POP_L: begin
                done    = 1'b1;
                pc_load = 1'b1;
                sp_fin  = sp_q + 16'd2;
                state_d = ST_IDLE;
            end
            ST_POP_D: begin
                done    = 1'b1;
                sp_fin  = sp_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A start in the done cycle chains directly; the register file has not
        // yet applied the last sp_op, so the base comes from the local copy.
        accept  = (state_q == ST_IDLE) || done;
        op      = accept ? pick_op(start_call, start_ret, start_push, start_pop)
                         : OP_NONE;
        sp_base = (state_q == ST_IDLE) ? {sph, spl} : sp_fin;

        case (op)
            OP_CALL, OP_PUSH: state_d = ST_PUSH_L;
            OP_RET,  OP_POP:  state_d = ST_POP_A;
            default: ;
        endcase
    end

    always_comb begin
        ram_adr        = '0;
        ram_adr[15:0]  = adr16;
    end

    assign ram_wdata = wdata_q;
    // Popped bytes are forwarded straight from RAM in the capture cycle.
    assign pc_out    = (state_q == ST_POP_L) ? {pch_q, ram_rdata} : pc_q;
    assign pop_data  = (state_q == ST_POP_D) ? ram_rdata : pop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sp_q       <= 16'h0000;
            call_q     <= 1'b0;
            ret_q      <= 1'b0;
            wdata_q    <= 8'h00;
            pch_hold_q <= 8'h00;
            pch_q      <= 8'h00;
            pc_q       <= 16'h0000;
            pop_q      <= 8'h00;
        end else begin
            state_q <= state_d;

            if (state_q == ST_PUSH_L && call_q) wdata_q <= pch_hold_q;
            if (state_q == ST_POP_H) pch_q <= ram_rdata;
            if (state_q == ST_POP_L) pc_q  <= {pch_q, ram_rdata};
            if (state_q == ST_POP_D) pop_q <= ram_rdata;

            if (op != OP_NONE) begin
                sp_q   <= sp_base;
                call_q <= (op == OP_CALL);
                ret_q  <= (op == OP_RET);
                if (op == OP_CALL) begin
                    wdata_q    <= pc_in[7:0];
                    pch_hold_q <= pc_in[15:8];
                end
                if (op == OP_PUSH) wdata_q <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// -----------------------------------------------------------------------------
// tb_stack_seq
// Bench for stack_seq with a RAM model and a register-file SP model.
// Expected per-cycle output records are queued when a start is driven and
// popped and compared on the following falling edges.
// -----------------------------------------------------------------------------
module tb_stack_seq;
    import stack_seq_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        we;
        logic        re;
        logic [1:0]  op;
        logic [15:0] adr;
        logic [7:0]  wd;
        logic        pcl;
        logic [15:0] pc;
        logic [7:0]  pd;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_call = 1'b0, start_ret = 1'b0, start_push = 1'b0, start_pop = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  push_data = 8'h00;
    logic [7:0]  ram_rdata = 8'h00;
    logic [15:0] ram_adr;
    logic        ram_we, ram_re;
    logic [7:0]  ram_wdata;
    logic [1:0]  sp_op;
    logic        busy, done, pc_load;
    logic [15:0] pc_out;
    logic [7:0]  pop_data;

    logic [15:0] rf_sp = 16'h0000;
    logic        sp_load = 1'b0;
    logic [15:0] sp_val = 16'h0000;
    logic [7:0]  mem [0:65535];

    int nvec = 0;
    int nerr = 0;
    cyc_t sq[$];
    logic [7:0]  m_wd = 8'h00;
    logic [15:0] m_pc = 16'h0000;
    logic [7:0]  m_pd = 8'h00;

    stack_seq #(.ADR_W(16)) dut (
        .clk(clk), .rst(rst),
        .start_call(start_call), .start_ret(start_ret),
        .start_push(start_push), .start_pop(start_pop),
        .pc_in(pc_in), .push_data(push_data),
        .spl(rf_sp[7:0]), .sph(rf_sp[15:8]),
        .ram_rdata(ram_rdata), .ram_adr(ram_adr),
        .ram_we(ram_we), .ram_re(ram_re), .ram_wdata(ram_wdata),
        .sp_op(sp_op), .busy(busy), .done(done),
        .pc_out(pc_out), .pc_load(pc_load), .pop_data(pop_data)
    );

    always #5 clk = ~clk;

    // RAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_adr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_adr];
    end

    // Register file SP: applies sp_op at the next edge.
    always @(posedge clk) begin
        if (sp_load)              rf_sp <= sp_val;
        else if (sp_op == SP_INC) rf_sp <= rf_sp + 16'd1;
        else if (sp_op == SP_DEC) rf_sp <= rf_sp - 16'd1;
    end

    function automatic cyc_t obs();
        return '{busy, done, ram_we, ram_re, sp_op, ram_adr, ram_wdata,
                 pc_load, pc_out, pop_data};
    endfunction

    function automatic cyc_t mk(input logic b, input logic d, input logic we,
                                input logic re, input logic [1:0] op,
                                input logic [15:0] adr, input logic pcl);
        return '{b, d, we, re, op, adr, m_wd, pcl, m_pc, m_pd};
    endfunction

    task automatic set_sp(input logic [15:0] v);
        @(negedge clk);
        sp_load = 1'b1;
        sp_val  = v;
        @(negedge clk);
        sp_load = 1'b0;
    endtask

    task automatic test_reset();
        cyc_t g;
        #3;
        g = obs();
        nvec++;
        if (g !== mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0)) begin
            nerr++;
            $display("FAIL reset_state: got %h, expected %h", g, mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_call();
        cyc_t e, g;
        set_sp(16'h10FF);
        m_wd = 8'h34; sq.push_back(mk(1, 0, 1, 0, SP_DEC, 16'h10FF, 0));
        m_wd = 8'h12; sq.push_back(mk(1, 1, 1, 0, SP_DEC, 16'h10FE, 0));
        sq.push_back(mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        pc_in = 16'h1234; start_call = 1'b1;
        while (sq.size() > 0) begin
            @(negedge clk);
            {start_call, start_ret, start_push, start_pop} = 4'b0000;
            e = sq.pop_front(); g = obs(); nvec++;
            if (g !== e) begin nerr++; $display("FAIL call_cycle: got %h, expected %h", g, e); end
        end
        nvec++;
        if ({mem[16'h10FF], mem[16'h10FE], rf_sp} !== {8'h34, 8'h12, 16'h10FD}) begin
            nerr++;
            $display("FAIL call_ram_sp: got %h %h sp %h, expected 34 12 sp 10fd", mem[16'h10FF], mem[16'h10FE], rf_sp);
        end
    endtask

    task automatic test_ret();
        cyc_t e, g;
        set_sp(16'h10FD);
        sq.push_back(mk(1, 0, 0, 1, SP_INC, 16'h10FE, 0));
        sq.push_back(mk(1, 0, 0, 1, SP_INC, 16'h10FF, 0));
        m_pc = 16'h1234; sq.push_back(mk(1, 1, 0, 0, SP_HOLD, 16'h0000, 1));
        sq.push_back(mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        start_ret = 1'b1;
        while (sq.size() > 0) begin
            @(negedge clk);
            {start_call, start_ret, start_push, start_pop} = 4'b0000;
            e = sq.pop_front(); g = obs(); nvec++;
            if (g !== e) begin nerr++; $display("FAIL ret_cycle: got %h, expected %h", g, e); end
        end
        nvec++;
        if (rf_sp !== 16'h10FF) begin nerr++; $display("FAIL ret_sp: got %h, expected 10ff", rf_sp); end
    endtask

    task automatic test_wrap();
        cyc_t e, g;
        set_sp(16'h0000);
        m_wd = 8'hA5; sq.push_back(mk(1, 1, 1, 0, SP_DEC, 16'h0000, 0));
        sq.push_back(mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        push_data = 8'hA5; start_push = 1'b1;
        while (sq.size() > 0) begin
            @(negedge clk);
            {start_call, start_ret, start_push, start_pop} = 4'b0000;
            e = sq.pop_front(); g = obs(); nvec++;
            if (g !== e) begin nerr++; $display("FAIL wrap_push: got %h, expected %h", g, e); end
        end
        nvec++;
        if ({mem[16'h0000], rf_sp} !== {8'hA5, 16'hFFFF}) begin
            nerr++; $display("FAIL wrap_push_sp: got %h sp %h, expected a5 sp ffff", mem[16'h0000], rf_sp);
        end

        set_sp(16'hFFFF);
        sq.push_back(mk(1, 0, 0, 1, SP_INC, 16'h0000, 0));
        m_pd = 8'hA5; sq.push_back(mk(1, 1, 0, 0, SP_HOLD, 16'h0000, 0));
        sq.push_back(mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        start_pop = 1'b1;
        while (sq.size() > 0) begin
            @(negedge clk);
            {start_call, start_ret, start_push, start_pop} = 4'b0000;
            e = sq.pop_front(); g = obs(); nvec++;
            if (g !== e) begin nerr++; $display("FAIL wrap_pop: got %h, expected %h", g, e); end
        end
        nvec++;
        if (rf_sp !== 16'h0000) begin nerr++; $display("FAIL wrap_pop_sp: got %h, expected 0000", rf_sp); end
    endtask

    task automatic test_priority();
        cyc_t e, g;
        int i;
        set_sp(16'h2000);
        m_wd = 8'hEF; sq.push_back(mk(1, 0, 1, 0, SP_DEC, 16'h2000, 0));
        m_wd = 8'hBE; sq.push_back(mk(1, 1, 1, 0, SP_DEC, 16'h1FFF, 0));
        sq.push_back(mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        sq.push_back(mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        pc_in = 16'hBEEF; start_call = 1'b1; start_pop = 1'b1;
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk);
            {start_call, start_ret, start_push, start_pop} = 4'b0000;
            e = sq.pop_front(); g = obs(); nvec++;
            if (g !== e) begin nerr++; $display("FAIL priority_cycle%0d: got %h, expected %h", i, g, e); end
            // Starts raised while busy (not in the done cycle) must be ignored.
            if (i == 0) begin
                push_data = 8'h77; start_ret = 1'b1; start_push = 1'b1; start_pop = 1'b1;
            end
            i++;
        end
        nvec++;
        if (rf_sp !== 16'h1FFE) begin nerr++; $display("FAIL priority_sp: got %h, expected 1ffe", rf_sp); end
    endtask

    task automatic test_reset_mid_ret();
        cyc_t e, g;
        set_sp(16'h10FD);
        sq.push_back(mk(1, 0, 0, 1, SP_INC, 16'h10FE, 0));
        sq.push_back(mk(1, 0, 0, 1, SP_INC, 16'h10FF, 0));
        start_ret = 1'b1;
        while (sq.size() > 0) begin
            @(negedge clk);
            {start_call, start_ret, start_push, start_pop} = 4'b0000;
            e = sq.pop_front(); g = obs(); nvec++;
            if (g !== e) begin nerr++; $display("FAIL midrst_cycle: got %h, expected %h", g, e); end
        end
        // Now in POP_H: assert reset between edges.
        rst = 1'b1;
        m_wd = 8'h00; m_pc = 16'h0000; m_pd = 8'h00;
        #1;
        g = obs(); nvec++;
        if (g !== mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0)) begin
            nerr++; $display("FAIL midrst_immediate: got %h, expected %h", g, mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        end
        @(negedge clk);
        g = obs(); nvec++;
        if ({g, rf_sp} !== {mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0), 16'h10FE}) begin
            nerr++; $display("FAIL midrst_held: got %h sp %h, expected %h sp 10fe", g, rf_sp, mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        end
        rst = 1'b0;
        @(negedge clk);
        m_wd = 8'h5A; sq.push_back(mk(1, 1, 1, 0, SP_DEC, 16'h10FE, 0));
        sq.push_back(mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        push_data = 8'h5A; start_push = 1'b1;
        while (sq.size() > 0) begin
            @(negedge clk);
            {start_call, start_ret, start_push, start_pop} = 4'b0000;
            e = sq.pop_front(); g = obs(); nvec++;
            if (g !== e) begin nerr++; $display("FAIL midrst_push: got %h, expected %h", g, e); end
        end
        nvec++;
        if ({mem[16'h10FE], rf_sp} !== {8'h5A, 16'h10FD}) begin
            nerr++; $display("FAIL midrst_push_ram: got %h sp %h, expected 5a sp 10fd", mem[16'h10FE], rf_sp);
        end
    endtask

    task automatic test_back_to_back();
        cyc_t e, g;
        int i;
        set_sp(16'h3000);
        m_wd = 8'h11; sq.push_back(mk(1, 1, 1, 0, SP_DEC, 16'h3000, 0));
        m_wd = 8'h22; sq.push_back(mk(1, 1, 1, 0, SP_DEC, 16'h2FFF, 0));
        sq.push_back(mk(1, 0, 0, 1, SP_INC, 16'h2FFF, 0));
        m_pd = 8'h22; sq.push_back(mk(1, 1, 0, 0, SP_HOLD, 16'h0000, 0));
        sq.push_back(mk(0, 0, 0, 0, SP_HOLD, 16'h0000, 0));
        push_data = 8'h11; start_push = 1'b1;
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk);
            {start_call, start_ret, start_push, start_pop} = 4'b0000;
            e = sq.pop_front(); g = obs(); nvec++;
            if (g !== e) begin nerr++; $display("FAIL b2b_cycle%0d: got %h, expected %h", i, g, e); end
            if (i == 0) begin push_data = 8'h22; start_push = 1'b1; end
            if (i == 1) start_pop = 1'b1;
            i++;
        end
        nvec++;
        if (rf_sp !== 16'h2FFF) begin nerr++; $display("FAIL b2b_sp: got %h, expected 2fff", rf_sp); end
    endtask

    initial begin
        test_reset();
        test_call();
        test_ret();
        test_wrap();
        test_priority();
        test_reset_mid_ret();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
